crc8_frame_checker: RTL
=======================

// Module: crc8_frame_checker
// PURPOSE
//  Streaming CRC-8 receive checker; sits directly upstream of the crc8 update logic and drives it one byte per beat.
//  - Accepts bytes on a valid/ready stream and accumulates CRC-8 (x^8+x^2+x+1, 0x07, left-shifting, unreflected).
//  - The last byte of each frame is the transmitted CRC. It is compared against the accumulated value.
//  - Presents one result record per frame on a valid/ready output.
//  - TMR target: module carries (* tamara_triplicate *).
// PARAMETERS
//  CRC_INIT  8'h00  CRC register value at start of each frame
//  XOR_OUT   8'h00  XORed onto accumulated CRC before compare/report
//  LEN_W     16     width of payload length counter (payload excludes CRC byte)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous assert, active-low reset
//  in_valid   in   1      input byte valid
//  in_ready   out  1      checker can accept a byte
//  in_data    in   8      input byte
//  in_last    in   1      marks final byte of frame (the CRC byte)
//  res_valid  out  1      result record valid
//  res_ready  in   1      downstream accepts record
//  res_ok     out  1      1 = received CRC matched
//  res_crc    out  8      computed CRC (after XOR_OUT)
//  res_len    out  LEN_W  payload byte count, saturating
//  error      out  1      (* tamara_error_sink *); tied 0 in RTL, driven by TMR voter
// BEHAVIOUR
//  - Reset (async, rst_n=0) sets state=IDLE, crc=CRC_INIT, len=0, res_valid=0, res_ok=0, res_crc=0, res_len=0.
//  - in_ready = (state != RESULT). It is a combinational decode of registered state only.
//  - Beat = in_valid & in_ready.
//  - States:
//    - IDLE: no bytes of current frame seen.
//      - Beat with !in_last -> crc<=step(CRC_INIT,in_data), len<=1, ACCUM.
//      - Beat with in_last -> zero-payload frame; compare in_data vs CRC_INIT^XOR_OUT, go RESULT.
//    - ACCUM: beat with !in_last -> crc<=step(crc,in_data), len<=len+1.
//      - Beat with in_last -> latch result, RESULT. The CRC byte is NOT fed into crc.
//    - RESULT: res_valid=1; record fields held stable.
//      - res_valid & res_ready -> crc<=CRC_INIT, len<=0, res_valid<=0, IDLE.
//  - Latching the result registers: res_crc<=crc^XOR_OUT, res_ok<=(in_data==crc^XOR_OUT), res_len<=len.
//  - Latency: last beat in cycle N -> res_valid=1 in cycle N+1.
//    - Earliest next input beat is the cycle after res handshake.
//  - No input beat can coincide with RESULT, because in_ready is low there.
//  - Length: len saturates at 2^LEN_W-1 and does not wrap. The CRC keeps accumulating.
//  - in_data/in_last are ignored when !in_valid. Input is not required to hold when in_ready=0.
//  - Reset mid-frame or mid-RESULT discards the partial frame and record. No result is emitted.
//  - step(c,d): one-byte parallel update. Bit equations are identical to the team's crc8 update block.
// STRUCTURE
//  - Shared package crc_pkg holds:
//    - CRC8_POLY=8'h07;
//    - state typedef {IDLE,ACCUM,RESULT};
//    - function crc8_step(c,d).
//  - One sub-module: the existing combinational crc8 update (crcIn=crc, data=in_data, crcOut=next).
//  - Instantiate it once. The IDLE path muxes CRC_INIT onto crcIn.
//  - Remainder is one FSM plus the counter/result registers; ~200 lines.
// TESTING
//  - "123456789" + CRC byte 8'hF4, res_ready=1 -> res_valid cycle after last.
//    - Expect res_ok=1, res_crc=8'hF4, res_len=9.
//  - Same payload, CRC byte 8'hF5 -> res_ok=0, res_crc=8'hF4, res_len=9.
//  - Single beat 8'h00 with in_last (zero payload) -> res_ok=1, res_crc=8'h00, res_len=0.
//  - Payload 8'h01, CRC 8'h07:
//    - Hold res_ready=0 for 5 cycles -> in_ready=0 and record stable throughout.
//    - After accept, in_ready=1 the next cycle.
//  - LEN_W=4, 20-byte payload -> res_len=15 (saturated), res_crc matches reference model.
//  - Assert rst_n=0 after 3 payload bytes, release, then send 8'h01,8'h07 -> exactly one record, res_ok=1, res_len=1.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC-8 definitions: polynomial, checker FSM states and a reference byte step.
// The step function runs bit-serially and shares no code with the parallel update block.
package crc_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESULT
    } state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ CRC8_POLY) : (r << 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/crc8_update.sv
// CRC-8 (0x07, MSB-first, unreflected) one-byte parallel update.
// Latency: combinational, 0 cycles.
// Backpressure: none; a pure function of its inputs.
module crc8_update
    import crc_pkg::*;
(
    input  logic [7:0] crcIn,
    input  logic [7:0] data,
    output logic [7:0] crcOut
);

    logic [7:0] t;

    assign t = crcIn ^ data;

    // Eight shift/XOR steps of the 0x07 polynomial collapsed into XOR trees.
    assign crcOut[0] = t[0] ^ t[6] ^ t[7];
    assign crcOut[1] = t[0] ^ t[1] ^ t[6];
    assign crcOut[2] = t[0] ^ t[1] ^ t[2] ^ t[6];
    assign crcOut[3] = t[1] ^ t[2] ^ t[3] ^ t[7];
    assign crcOut[4] = t[2] ^ t[3] ^ t[4];
    assign crcOut[5] = t[3] ^ t[4] ^ t[5];
    assign crcOut[6] = t[4] ^ t[5] ^ t[6];
    assign crcOut[7] = t[5] ^ t[6] ^ t[7];

endmodule

// File: rtl/crc8_frame_checker.sv
// Streaming CRC-8 frame checker; the last byte of a frame is the received CRC.
// Latency: result record is valid the cycle after the last input beat.
// Backpressure: in_ready drops while a record waits; the record is held until res_ready.
(* tamara_triplicate *)
module crc8_frame_checker
    import crc_pkg::*;
#(
    parameter logic [7:0] CRC_INIT = 8'h00,
    parameter logic [7:0] XOR_OUT  = 8'h00,
    parameter int         LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic [7:0]       res_crc,
    output logic [LEN_W-1:0] res_len,
    (* tamara_error_sink *)
    output logic             error
);

    state_t           state;
    state_t           stateNxt;
    logic [7:0]       crc;
    logic [7:0]       crcIn;
    logic [7:0]       crcNext;
    logic [7:0]       cmpCrc;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] lenInc;
    logic             beat;

    assign in_ready = (state != RESULT);
    assign beat     = in_valid & in_ready;
    assign error    = 1'b0;

    // A frame's first byte always starts from CRC_INIT, so the IDLE path bypasses the register.
    assign crcIn  = (state == IDLE) ? CRC_INIT : crc;
    assign cmpCrc = crcIn ^ XOR_OUT;
    assign lenInc = (len == '1) ? len : len + LEN_W'(1);

    crc8_update u_update (
        .crcIn  (crcIn),
        .data   (in_data),
        .crcOut (crcNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE, ACCUM: begin
                if (beat) begin
                    stateNxt = in_last ? RESULT : ACCUM;
                end
            end
            RESULT: begin
                if (res_valid && res_ready) begin
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc       <= CRC_INIT;
            len       <= '0;
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
            res_crc   <= 8'h00;
            res_len   <= '0;
        end else begin
            if (beat && !in_last) begin
                crc <= crcNext;
                len <= (state == IDLE) ? LEN_W'(1) : lenInc;
            end
            // The CRC byte itself is only compared, never folded into the running CRC.
            if (beat && in_last) begin
                res_valid <= 1'b1;
                res_crc   <= cmpCrc;
                res_ok    <= (in_data == cmpCrc);
                res_len   <= len;
            end
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
                crc       <= CRC_INIT;
                len       <= '0;
            end
        end
    end

endmodule
